mc_ctrl: RTL

Multi-cycle control FSM for the P-series MIPS core. It sequences instruction fetch, decode, execute, memory access and write-back, and it drives the existing next-PC unit through `pc_we` and `npc_op`. The PC is updated exactly once per instruction, in that instruction's final state, so branch targets are computed relative to the unmodified PC. Data memory is accessed through a ready handshake, so the core tolerates multi-cycle memories.

---
 rtl/mc_pkg.sv | 59 +++++
 rtl/mc_decode.sv | 33 +++
 rtl/mc_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
// The npc_op values are fixed by the existing next-PC unit and must not change.
package mc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      IC_RALU    = 4'd0,
      IC_ORI     = 4'd1,
      IC_LUI     = 4'd2,
      IC_LW      = 4'd3,
      IC_SW      = 4'd4,
      IC_BEQ     = 4'd5,
      IC_J       = 4'd6,
      IC_JAL     = 4'd7,
      IC_JR      = 4'd8,
      IC_NOP     = 4'd9,
      IC_ILLEGAL = 4'd10
   } iclass_e;

   localparam logic [2:0] NPC_PC4    = 3'b000;
   localparam logic [2:0] NPC_BRANCH = 3'b001;
   localparam logic [2:0] NPC_JUMP   = 3'b010;
   localparam logic [2:0] NPC_JR     = 3'b100;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_NOP  = 6'b000000;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_LUI = 3'b011;

   localparam logic [1:0] DST_RT = 2'b00;
   localparam logic [1:0] DST_RD = 2'b01;
   localparam logic [1:0] DST_RA = 2'b10;

   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC4 = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class.
// Anything not explicitly supported falls through to IC_ILLEGAL.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] iclass
);

   always_comb begin
      iclass = IC_ILLEGAL;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU, FN_SUBU: iclass = IC_RALU;
               FN_JR:            iclass = IC_JR;
               FN_NOP:           iclass = IC_NOP;
               default:          iclass = IC_ILLEGAL;
            endcase
         end
         OP_ORI:  iclass = IC_ORI;
         OP_LUI:  iclass = IC_LUI;
         OP_LW:   iclass = IC_LW;
         OP_SW:   iclass = IC_SW;
         OP_BEQ:  iclass = IC_BEQ;
         OP_J:    iclass = IC_J;
         OP_JAL:  iclass = IC_JAL;
         default: iclass = IC_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives the
// next-PC unit so the PC moves exactly once, in each instruction's last state.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int RA_IDX = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        ir_we,
   output logic        pc_we,
   output logic [2:0]  npc_op,
   output logic        reg_we,
   output logic [1:0]  reg_dst,
   output logic [1:0]  wd_sel,
   output logic        alu_src,
   output logic [2:0]  alu_op,
   output logic        ext_op,
   output logic        mem_re,
   output logic        mem_we,
   output logic        illegal,
   output logic [2:0]  state,
   output logic [31:0] instret
);

   // reg_dst = 10 selects RA_IDX in the datapath; reject indices outside the register file.
   generate
      if (RA_IDX < 0 || RA_IDX > 31) begin : g_bad_ra_idx
         $error("mc_ctrl: RA_IDX must be in 0..31");
      end
   endgenerate

   state_e     state_q;
   state_e     state_d;
   logic [3:0] iclass_raw;
   iclass_e    iclass;

   logic       ir_raw;
   logic       pc_raw;
   logic       reg_raw;
   logic       re_raw;
   logic       we_raw;
   logic       ill_raw;

   logic [2:0] ex_alu_op;
   logic       ex_alu_src;
   logic       ex_ext_op;

   mc_decode u_decode (
      .opcode (opcode),
      .funct  (funct),
      .iclass (iclass_raw)
   );

   assign iclass = iclass_e'(iclass_raw);
   assign state  = state_q;

   // ALU controls for the instruction; shared by EXEC and WB so the result stays stable.
   always_comb begin
      ex_alu_op  = ALU_ADD;
      ex_alu_src = 1'b0;
      ex_ext_op  = 1'b0;
      case (iclass)
         IC_RALU: ex_alu_op = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
         IC_ORI: begin
            ex_alu_op  = ALU_OR;
            ex_alu_src = 1'b1;
         end
         IC_LUI: begin
            ex_alu_op  = ALU_LUI;
            ex_alu_src = 1'b1;
         end
         IC_LW, IC_SW: begin
            ex_alu_src = 1'b1;
            ex_ext_op  = 1'b1;
         end
         IC_BEQ:  ex_alu_op = ALU_SUB;
         default: ex_alu_op = ALU_ADD;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ir_raw  = 1'b0;
      pc_raw  = 1'b0;
      reg_raw = 1'b0;
      re_raw  = 1'b0;
      we_raw  = 1'b0;
      ill_raw = 1'b0;
      npc_op  = NPC_PC4;
      reg_dst = DST_RT;
      wd_sel  = WD_ALU;
      alu_src = 1'b0;
      alu_op  = ALU_ADD;
      ext_op  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            ir_raw  = 1'b1;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            state_d = ST_FETCH;
            case (iclass)
               IC_J: begin
                  pc_raw = 1'b1;
                  npc_op = NPC_JUMP;
               end
               IC_JAL: begin
                  pc_raw  = 1'b1;
                  npc_op  = NPC_JUMP;
                  reg_raw = 1'b1;
                  reg_dst = DST_RA;
                  wd_sel  = WD_PC4;
               end
               IC_JR: begin
                  pc_raw = 1'b1;
                  npc_op = NPC_JR;
               end
               IC_NOP: pc_raw = 1'b1;
               IC_ILLEGAL: begin
                  ill_raw = 1'b1;
                  pc_raw  = 1'b1;
               end
               default: state_d = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            alu_op  = ex_alu_op;
            alu_src = ex_alu_src;
            ext_op  = ex_ext_op;
            case (iclass)
               IC_RALU, IC_ORI, IC_LUI: state_d = ST_WB;
               IC_LW, IC_SW:            state_d = ST_MEM;
               IC_BEQ: begin
                  pc_raw  = 1'b1;
                  npc_op  = zero ? NPC_BRANCH : NPC_PC4;
                  state_d = ST_FETCH;
               end
               default: state_d = ST_FETCH;
            endcase
         end
         // Strobes stay up until the memory reports completion.
         ST_MEM: begin
            case (iclass)
               IC_LW: begin
                  re_raw = 1'b1;
                  if (mem_ready) state_d = ST_WB;
               end
               IC_SW: begin
                  we_raw = 1'b1;
                  if (mem_ready) begin
                     pc_raw  = 1'b1;
                     state_d = ST_FETCH;
                  end
               end
               default: state_d = ST_FETCH;
            endcase
         end
         ST_WB: begin
            alu_op  = ex_alu_op;
            alu_src = ex_alu_src;
            ext_op  = ex_ext_op;
            reg_raw = 1'b1;
            pc_raw  = 1'b1;
            wd_sel  = (iclass == IC_LW) ? WD_MEM : WD_ALU;
            reg_dst = (iclass == IC_RALU) ? DST_RD : DST_RT;
            state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // Reset suppresses every side-effecting strobe, abandoning any access in flight.
   assign ir_we   = ir_raw  & ~reset;
   assign pc_we   = pc_raw  & ~reset;
   assign reg_we  = reg_raw & ~reset;
   assign mem_re  = re_raw  & ~reset;
   assign mem_we  = we_raw  & ~reset;
   assign illegal = ill_raw & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         instret <= 32'd0;
      end else begin
         state_q <= state_d;
         if (pc_we) instret <= instret + 32'd1;
      end
   end

endmodule
